// File: rtl/scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guard interval and per-digit blanking.
// Optional build macro SCAN_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits 3..1.
module scan_ctrl #(
    parameter int PRESCALE_BITS = 17,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        scan_tick
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        DRIVE
    } state_t;

    state_t                   state;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic [GW-1:0]            guard_cnt;
    logic                     tick_now;
    logic [3:0]               auto_blank;
    logic [3:0]               nibble;
    logic                     slot_dark;

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        auto_blank = 4'b0000;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero only if every digit above it is one too.
        auto_blank[3] = (digits[15:12] == 4'h0) && !dp_in[3];
        auto_blank[2] = auto_blank[3] && (digits[11:8] == 4'h0) && !dp_in[2];
        auto_blank[1] = auto_blank[2] && (digits[7:4] == 4'h0) && !dp_in[1];
`endif
    end

    always_comb begin
        tick_now  = enable && (prescaler == '1);
        nibble    = digits[{digit_sel, 2'b00} +: 4];
        slot_dark = blank[digit_sel] || auto_blank[digit_sel];
    end

    // NOTE: async reset clears every register here, outputs included, so the
    // display goes dark the instant reset falls rather than at the next edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            scan_tick <= 1'b0;
            state     <= IDLE;
            digit_sel <= 2'd0;
            guard_cnt <= '0;
            anode     <= 4'b1111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // pre-edge values, so statement order below does not matter.
            prescaler <= enable ? prescaler + PRESCALE_BITS'(1) : '0;
            scan_tick <= tick_now;

            if (enable && state == DRIVE && !slot_dark) begin
                anode <= ~(4'b0001 << digit_sel);
                seg   <= hex7(nibble);
                dp    <= ~dp_in[digit_sel];
            end else begin
                anode <= 4'b1111;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end

            if (!enable) begin
                state     <= IDLE;
                digit_sel <= 2'd0;
                guard_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= GUARD;
                        digit_sel <= 2'd0;
                        guard_cnt <= '0;
                    end
                    GUARD: begin
                        // A digit advance takes priority over finishing the guard.
                        if (tick_now) begin
                            digit_sel <= digit_sel + 2'd1;
                            guard_cnt <= '0;
                        end else if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                            state <= DRIVE;
                        end else begin
                            guard_cnt <= guard_cnt + GW'(1);
                        end
                    end
                    DRIVE: begin
                        if (tick_now) begin
                            state     <= GUARD;
                            digit_sel <= digit_sel + 2'd1;
                            guard_cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        digit_sel <= 2'd0;
                        guard_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: expected display states are queued by the stimulus
// and popped by a monitor each time {anode,seg,dp} changes.
module tb_scan_ctrl;

    localparam int PB = 3;
    localparam int GC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        scan_tick;

    scan_ctrl #(.PRESCALE_BITS(PB), .GUARD_CYCLES(GC)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .digits    (digits),
        .dp_in     (dp_in),
        .blank     (blank),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel),
        .scan_tick (scan_tick)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    disp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    timing_en = 1'b0;

    function automatic disp_t mk(input logic [3:0] a, input logic [6:0] s, input logic d);
        disp_t r;
        r.anode = a;
        r.seg   = s;
        r.dp    = d;
        return r;
    endfunction

    function automatic disp_t dark();
        return mk(4'b1111, 7'h7F, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops on every display change; also measures tick period and guard length.
    initial begin
        disp_t prev;
        disp_t cur;
        int since_tick;
        int dark_run;
        bit seen_lit;
        since_tick = -1;
        dark_run   = 0;
        seen_lit   = 1'b0;
        forever begin
            @(negedge clock);
            cur = {anode, seg, dp};
            if (mon_en && cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_display actual=%h required=none at %0t", cur, $time);
                end else begin
                    check("display", cur, exp_q.pop_front());
                end
            end
            if (!timing_en) begin
                since_tick = -1;
                dark_run   = 0;
                seen_lit   = 1'b0;
            end else begin
                if (since_tick >= 0) since_tick++;
                if (scan_tick) begin
                    if (since_tick > 0) check("tick_period", since_tick, 1 << PB);
                    since_tick = 0;
                end
                if (anode == 4'b1111) begin
                    dark_run++;
                end else begin
                    if (seen_lit && dark_run > 0) check("guard_len", dark_run, GC);
                    seen_lit = 1'b1;
                    dark_run = 0;
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_anode", anode, 4'b1111);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_digit_sel", digit_sel, 2'd0);
        check("rst_scan_tick", scan_tick, 1'b0);

        // Free run on 1234: 4,3,2,1,4 with dark guard gaps.
        exp_q.push_back(mk(4'b1110, 7'h19, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1101, 7'h30, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1011, 7'h24, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b0111, 7'h79, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1110, 7'h19, 1'b1));
        mon_en    = 1'b1;
        timing_en = 1'b1;
        reset     = 1'b1;
        enable    = 1'b1;
        wait_empty("free_run_drain", 60);
        timing_en = 1'b0;

        // Drop enable while digit 2 is lit, then restart from digit 0.
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1101, 7'h30, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1011, 7'h24, 1'b1));
        wait_empty("to_digit2", 30);
        exp_q.push_back(dark());
        enable = 1'b0;
        @(negedge clock);
        check("disable_anode", anode, 4'b1111);
        check("disable_digit_sel", digit_sel, 2'd0);
        repeat (3) @(negedge clock);
        exp_q.push_back(mk(4'b1110, 7'h19, 1'b1));
        enable = 1'b1;
        wait_empty("reenable_drain", 20);
        check("reenable_digit_sel", digit_sel, 2'd0);

        // Forced blank of digit 2 on FFFF, decimal point on digit 1.
        exp_q.push_back(dark());
        enable = 1'b0;
        wait_empty("stop_c", 5);
        digits = 16'hFFFF;
        blank  = 4'b0100;
        dp_in  = 4'b0010;
        exp_q.push_back(mk(4'b1110, 7'h0E, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1101, 7'h0E, 1'b0));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b0111, 7'h0E, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1110, 7'h0E, 1'b1));
        enable = 1'b1;
        wait_empty("blank_drain", 60);

        // 0050: leading zeros dark only with the auto-blank build.
        exp_q.push_back(dark());
        enable = 1'b0;
        wait_empty("stop_d", 5);
        digits = 16'h0050;
        blank  = 4'b0000;
        dp_in  = 4'b0000;
        exp_q.push_back(mk(4'b1110, 7'h40, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b1101, 7'h12, 1'b1));
        exp_q.push_back(dark());
`ifndef SCAN_LEADING_ZERO_BLANK_EN
        exp_q.push_back(mk(4'b1011, 7'h40, 1'b1));
        exp_q.push_back(dark());
        exp_q.push_back(mk(4'b0111, 7'h40, 1'b1));
        exp_q.push_back(dark());
`endif
        exp_q.push_back(mk(4'b1110, 7'h40, 1'b1));
        enable = 1'b1;
        wait_empty("zero_drain", 60);

        // Nibble change while digit 0 is lit shows within one clock.
        exp_q.push_back(mk(4'b1110, 7'h78, 1'b1));
        digits = 16'h0057;
        wait_empty("live_update", 2);

        // Asynchronous reset mid-drive, checked between clock edges.
        mon_en = 1'b0;
        for (int i = 0; i < 20 && anode == 4'b1111; i++) @(negedge clock);
        check("pre_reset_lit", anode != 4'b1111, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("async_anode", anode, 4'b1111);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dp, 1'b1);
        check("async_digit_sel", digit_sel, 2'd0);
        check("async_scan_tick", scan_tick, 1'b0);
        repeat (2) @(negedge clock);
        exp_q.push_back(mk(4'b1110, 7'h78, 1'b1));
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_empty("post_reset_digit0", 20);
        check("post_reset_digit_sel", digit_sel, 2'd0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
